// File: rtl/trace_drain_ctrl.sv
// trace_drain_ctrl
//   Output-side controller for the Gouram trace unit. Captures 128-bit trace
//   records into a small FIFO while armed. Serialises each record into four
//   32-bit beats, least-significant word first, on a valid/ready stream.
//   Records dropped on a full FIFO are counted so the host can detect loss.
//
// Parameters
//   FIFO_DEPTH  record slots (power of two, >= 2)
//   OVF_WIDTH   width of the saturating overflow counter
//
// Ports
//   clk, rst_n               clock / asynchronous active-low reset
//   trace_data_i             record from Gouram
//   trace_capture_enable_i   one-cycle record-valid strobe
//   arm_i, disarm_i          open / close the capture window (disarm wins)
//   m_data_o, m_valid_o,
//   m_ready_i, m_last_o      beat stream toward the sink
//   busy_o                   controller not idle
//   fifo_count_o             records held, including the one being serialised
//   overflow_count_o         records dropped in the current window
//   records_sent_o           records fully transferred in the current window
module trace_drain_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int OVF_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [127:0]                  trace_data_i,
   input  logic                          trace_capture_enable_i,
   input  logic                          arm_i,
   input  logic                          disarm_i,
   output logic [31:0]                   m_data_o,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic                          m_last_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic [OVF_WIDTH-1:0]          overflow_count_o,
   output logic [31:0]                   records_sent_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]           state;
   logic [127:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic [1:0]           idx;
   logic [OVF_WIDTH-1:0] ovf_cnt;
   logic [31:0]          sent_cnt;

   logic                 strobe_run;
   logic                 push;
   logic                 drop;
   logic                 beat_xfer;
   logic                 pop;
   logic [127:0]         head;
   logic [31:0]          head_word;

   // Full/empty are decided from the registered count only, so a pop in the
   // same cycle never frees a slot for a simultaneous strobe.
   assign strobe_run = (state == S_RUN) && trace_capture_enable_i;
   assign push       = strobe_run && (count < FULL_COUNT);
   assign drop       = strobe_run && (count == FULL_COUNT);
   assign beat_xfer  = m_valid_o && m_ready_i;
   assign pop        = beat_xfer && (idx == 2'd3);

   assign head = mem[rd_ptr];

   always_comb begin
      head_word = head[31:0];
      case (idx)
         2'd0: head_word = head[31:0];
         2'd1: head_word = head[63:32];
         2'd2: head_word = head[95:64];
         2'd3: head_word = head[127:96];
         default: head_word = head[31:0];
      endcase
   end

   // Data is forced to zero while nothing is valid so the unreset storage
   // never shows on the port (all outputs read 0 out of reset).
   assign m_valid_o        = (count != '0);
   assign m_data_o         = m_valid_o ? head_word : '0;
   assign m_last_o         = m_valid_o && (idx == 2'd3);
   assign busy_o           = (state != S_IDLE);
   assign fifo_count_o     = count;
   assign overflow_count_o = ovf_cnt;
   assign records_sent_o   = sent_cnt;

   // Record storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= trace_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (arm_i && !disarm_i) state <= S_RUN;
            S_RUN:   if (disarm_i)           state <= S_DRAIN;
            S_DRAIN: if (count == '0)        state <= S_IDLE;
            default:                         state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         idx    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (beat_xfer) idx <= idx + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt  <= '0;
         sent_cnt <= '0;
      end else if (state == S_IDLE) begin
         // FIFO is empty and strobes are ignored in IDLE, so arming can clear
         // without racing a pop or a drop.
         if (arm_i && !disarm_i) begin
            ovf_cnt  <= '0;
            sent_cnt <= '0;
         end
      end else begin
         if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_WIDTH'(1);
         if (pop) sent_cnt <= sent_cnt + 32'd1;
      end
   end

endmodule

// File: doc/trace_drain_ctrl.md
# trace_drain_ctrl

Output-side controller for the Gouram trace unit. It accepts 128-bit trace records whenever `trace_capture_enable` pulses and buffers them in a small FIFO. It serialises each record into four 32-bit beats on a valid/ready stream toward a narrower sink (BRAM writer, debug UART, DMA). An arm/disarm state machine sets the capture window, and dropped records are counted so the host can detect trace loss.

## Interface
- `FIFO_DEPTH`, 4: record slots; power of two, ≥ 2.
- `OVF_WIDTH`, 16: width of the overflow counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `trace_data_i`  in  128  record from Gouram `trace_data_o`.
- `trace_capture_enable_i`  in  1  one-cycle record-valid strobe from Gouram.
- `arm_i`  in  1  level; start a capture window.
- `disarm_i`  in  1  level; end the capture window.
- `m_data_o`  out  32  current beat.
- `m_valid_o`  out  1  beat valid.
- `m_ready_i`  in  1  sink accepts beat.
- `m_last_o`  out  1  marks beat 3 of a record.
- `busy_o`  out  1  state ≠ IDLE.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  records held, including the one being serialised.
- `overflow_count_o`  out  OVF_WIDTH  records dropped in the current window.
- `records_sent_o`  out  32  records fully transferred in the current window.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Strobes are ignored, not counted.
  - `arm_i`=1 (and `disarm_i`=0) moves to RUN, clears `overflow_count_o` and `records_sent_o` at that edge.
  - FIFO is always empty on entry to IDLE.
- RUN:
  - A strobe with registered `fifo_count_o` < FIFO_DEPTH pushes `trace_data_i`.
  - A strobe with `fifo_count_o` == FIFO_DEPTH drops the record and increments `overflow_count_o`, saturating at all-ones.
  - The full check uses the pre-edge count. A pop completing in the same cycle does not rescue the push.
  - `disarm_i`=1 moves to DRAIN. A strobe in the same cycle is still captured.
- DRAIN:
  - No pushes. Strobes are ignored, not counted as overflow.
  - Moves to IDLE on the cycle after FIFO count reaches 0.
  - `arm_i` is ignored.
- `arm_i` and `disarm_i` both high: `disarm_i` wins.
- Serialiser:
  - Serialises the FIFO head using a 2-bit beat index.
  - `m_data_o` = head[32·idx+31 : 32·idx]; least-significant word first.
  - `m_last_o` = (idx==3) & `m_valid_o`.
  - `m_valid_o` = (count ≠ 0).
- Beat handshake:
  - A beat transfers when `m_valid_o` & `m_ready_i` are high at an edge. idx then increments.
  - On transfer of beat 3: idx wraps to 0, head pops, `records_sent_o` increments (wraps mod 2^32).
- Stability: once `m_valid_o` is high, `m_data_o` and `m_last_o` hold until the beat is accepted. `m_valid_o` never drops without a transfer, except at reset.
- Simultaneous push and pop: count unchanged; the new record lands at the tail.
- Pointer wrap: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count is tracked separately; full and empty are decided from count alone.

## Timing
- Reset (async assert, sync release) values:
  - All outputs 0.
  - State IDLE, pointers 0, idx 0, counters 0.
  - Reset mid-record abandons it: `m_valid_o` falls immediately with `rst_n`.
- Latency: a strobe at edge N into an empty FIFO gives `m_valid_o`=1 with beat 0 after edge N.
- Throughput with `m_ready_i` held high: one beat per cycle, 4 cycles per record. Sustainable strobe rate is 1 per 4 cycles.
- `fifo_count_o` updates at the edge of push or pop.
- `busy_o` deasserts at the same edge that enters IDLE.
- Arm to capture: the first strobe accepted is the one sampled in the cycle after the arming edge.

## Test plan
- Basic capture:
  - Stimulus: arm, one strobe with data 0x0000000D_0000000C_0000000B_0000000A, `m_ready_i`=1.
  - Response: beats 0xA, 0xB, 0xC, 0xD on 4 consecutive cycles; `m_last_o` only on 0xD; `records_sent_o`=1.
- Backpressure:
  - Stimulus: same record; `m_ready_i` toggles 1,0,0,1,0,1,1.
  - Response: each beat held stable while not ready; exactly 4 transfers, in order; no duplicate or skipped beat.
- Overflow (FIFO_DEPTH=4):
  - Stimulus: `m_ready_i`=0; strobes in 6 consecutive cycles.
  - Response: `fifo_count_o`=4, `overflow_count_o`=2. After raising ready, exactly records 1–4 emerge (16 beats).
- Full plus pop in the same cycle:
  - Stimulus: FIFO full; beat 3 accepted in the same cycle as a strobe.
  - Response: strobe dropped, `overflow_count_o`+1, count 3.
- Disarm and drain:
  - Stimulus: 3 records queued; assert `disarm_i` together with a 4th strobe.
  - Response: state DRAIN, 4 records emitted, further strobes ignored; IDLE after the last beat; `busy_o`=0.
- Reset mid-record and re-arm:
  - Stimulus: `rst_n` low during beat 2.
  - Response: all outputs 0 immediately. After re-arm, the counters read 0 and a new record starts at beat 0.
  - Stimulus: `arm_i` and `disarm_i` both high from IDLE.
  - Response: remains IDLE.
